// File: rtl/data_mem_responder.sv
// Byte-addressed data memory responder with a fixed access latency and a req/ack handshake.
// The request is captured on accept; storage is read or merged on the WAIT->ACK edge.
module data_mem_responder #(
   parameter int ADDR_BITS = 16,
   parameter int LATENCY   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic        mem_write_en,
   input  logic [3:0]  mem_byte_en,
   input  logic [7:0]  mem_data_in  [0:3],
   output logic [7:0]  mem_data_out [0:3],
   output logic        mem_ack,
   output logic        mem_busy,
   output logic        mem_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   localparam int                   DEPTH     = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LANE_MASK = ADDR_BITS'(3);

   state_t               r_state;
   state_t               w_next;
   logic [7:0]           r_cnt;
   logic [ADDR_BITS-1:0] r_base;
   logic                 r_oor;
   logic                 r_we;
   logic [3:0]           r_be;
   logic [7:0]           r_wdata [0:3];
   logic [7:0]           r_mem   [0:DEPTH-1];

   logic w_accept;
   logic w_complete;
   logic w_oor;

   assign w_accept   = (r_state == S_IDLE) && mem_req;
   assign w_complete = (r_state == S_WAIT) && (r_cnt == 8'd0);
   assign w_oor      = (mem_addr >> ADDR_BITS) != 32'd0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (mem_req) w_next = S_WAIT;
         S_WAIT:  if (r_cnt == 8'd0) w_next = S_ACK;
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_ack  = (r_state == S_ACK);
      mem_busy = (r_state == S_WAIT) || (r_state == S_ACK);
   end

   // Request capture, latency count and the registered response word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= 8'd0;
         r_base  <= '0;
         r_oor   <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= 4'h0;
         mem_err <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_wdata[i]      <= 8'h00;
            mem_data_out[i] <= 8'h00;
         end
      end else begin
         if (w_accept) begin
            r_cnt  <= 8'(LATENCY - 1);
            r_base <= mem_addr[ADDR_BITS-1:0] & ~LANE_MASK;
            r_oor  <= w_oor;
            r_we   <= mem_write_en;
            r_be   <= mem_byte_en;
            for (int i = 0; i < 4; i++) r_wdata[i] <= mem_data_in[i];
         end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
         end

         if (w_complete) begin
            mem_err <= r_oor;
            for (int i = 0; i < 4; i++) begin
               if (r_oor)                mem_data_out[i] <= 8'h00;
               else if (r_we && r_be[i]) mem_data_out[i] <= r_wdata[i];
               else                      mem_data_out[i] <= r_mem[r_base | ADDR_BITS'(i)];
            end
         end
      end
   end

   // NOTE: storage has no reset branch; a reset must leave its contents intact and
   // an async clear of a whole array would also prevent RAM inference.
   always_ff @(posedge clk) begin
      if (w_complete && r_we && !r_oor) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) r_mem[r_base | ADDR_BITS'(i)] <= r_wdata[i];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=4 instance for the functional
// scenarios and a LATENCY=1 instance for the back-to-back handshake timing.
module tb_data_mem_responder;

   localparam int LAT_A = 4;
   localparam int LAT_B = 1;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   total;
   int   bad;

   logic        a_req, a_we, a_ack, a_busy, a_err;
   logic [31:0] a_addr;
   logic [3:0]  a_be;
   logic [7:0]  a_din  [0:3];
   logic [7:0]  a_dout [0:3];

   logic        b_req, b_we, b_ack, b_busy, b_err;
   logic [31:0] b_addr;
   logic [3:0]  b_be;
   logic [7:0]  b_din  [0:3];
   logic [7:0]  b_dout [0:3];

   exp_t       q_a[$];
   exp_t       q_b[$];
   exp_t       mon_a_e;
   exp_t       mon_b_e;
   logic [7:0] model_a [int];
   int         acks_a;
   logic       a_prev_ack;
   logic       b_prev_ack;

   data_mem_responder #(.ADDR_BITS(16), .LATENCY(LAT_A)) u_dut (
      .clk(clk), .reset(reset), .mem_req(a_req), .mem_addr(a_addr),
      .mem_write_en(a_we), .mem_byte_en(a_be), .mem_data_in(a_din),
      .mem_data_out(a_dout), .mem_ack(a_ack), .mem_busy(a_busy), .mem_err(a_err)
   );

   data_mem_responder #(.ADDR_BITS(16), .LATENCY(LAT_B)) u_dut_l1 (
      .clk(clk), .reset(reset), .mem_req(b_req), .mem_addr(b_addr),
      .mem_write_en(b_we), .mem_byte_en(b_be), .mem_data_in(b_din),
      .mem_data_out(b_dout), .mem_ack(b_ack), .mem_busy(b_busy), .mem_err(b_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   // Scoreboard monitor for the LATENCY=4 instance.
   always @(negedge clk) begin
      if (a_ack) begin
         acks_a++;
         total++;
         if (a_prev_ack) begin
            bad++;
            $display("FAIL a_ack_width: ack high on consecutive cycles at cyc=%0d, required one-cycle pulse", cyc);
         end
         total++;
         if (q_a.size() == 0) begin
            bad++;
            $display("FAIL a_unexpected_ack: ack at cyc=%0d with no request outstanding", cyc);
         end else begin
            mon_a_e = q_a.pop_front();
            total += 2;
            if ({a_dout[0], a_dout[1], a_dout[2], a_dout[3]} !== mon_a_e.data) begin
               bad++;
               $display("FAIL a_data: got %h required %h", {a_dout[0], a_dout[1], a_dout[2], a_dout[3]}, mon_a_e.data);
            end
            if (a_err !== mon_a_e.err) begin
               bad++;
               $display("FAIL a_err: got %b required %b", a_err, mon_a_e.err);
            end
            total++;
            if (cyc !== mon_a_e.cyc + LAT_A) begin
               bad++;
               $display("FAIL a_latency: ack at cyc=%0d required cyc=%0d", cyc, mon_a_e.cyc + LAT_A);
            end
         end
      end
      a_prev_ack = a_ack;
   end

   // Scoreboard monitor for the LATENCY=1 instance.
   always @(negedge clk) begin
      if (b_ack) begin
         total++;
         if (b_prev_ack) begin
            bad++;
            $display("FAIL b_ack_width: ack high on consecutive cycles at cyc=%0d", cyc);
         end
         total++;
         if (q_b.size() == 0) begin
            bad++;
            $display("FAIL b_unexpected_ack: ack at cyc=%0d with no request outstanding", cyc);
         end else begin
            mon_b_e = q_b.pop_front();
            total += 3;
            if ({b_dout[0], b_dout[1], b_dout[2], b_dout[3]} !== mon_b_e.data) begin
               bad++;
               $display("FAIL b_data: got %h required %h", {b_dout[0], b_dout[1], b_dout[2], b_dout[3]}, mon_b_e.data);
            end
            if (b_err !== mon_b_e.err) begin
               bad++;
               $display("FAIL b_err: got %b required %b", b_err, mon_b_e.err);
            end
            if (cyc !== mon_b_e.cyc + LAT_B) begin
               bad++;
               $display("FAIL b_latency: ack at cyc=%0d required cyc=%0d", cyc, mon_b_e.cyc + LAT_B);
            end
         end
      end
      b_prev_ack = b_ack;
   end

   task automatic drive_a(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
      a_addr = addr;
      a_we   = we;
      a_be   = be;
      for (int i = 0; i < 4; i++) a_din[i] = wd[31-8*i -: 8];
   endtask

   // One request on the LATENCY=4 instance; expected response comes from a byte model.
   task automatic do_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input bit churn);
      exp_t e;
      int   base;
      int   start;
      int   n;
      e.err  = (addr >> 16) != 32'd0;
      base   = int'(addr[15:2]) * 4;
      e.data = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (!e.err && we && be[i]) model_a[base + i] = wd[31-8*i -: 8];
         if (!e.err && model_a.exists(base + i)) e.data[31-8*i -: 8] = model_a[base + i];
      end
      drive_a(addr, we, be, wd);
      a_req = 1'b1;
      start = acks_a;
      @(posedge clk);
      #1;
      e.cyc = cyc;
      q_a.push_back(e);
      a_req = 1'b0;
      total++;
      if (a_busy !== 1'b1) begin
         bad++;
         $display("FAIL a_busy_after_accept: got %b required 1", a_busy);
      end
      n = 0;
      while (acks_a == start && n < LAT_A + 10) begin
         if (churn) drive_a($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
         @(negedge clk);
         #1;
         n++;
      end
      if (acks_a == start) begin
         total++;
         bad++;
         $display("FAIL a_ack_timeout: no ack within %0d cycles for addr %h", n, addr);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      total += 8;
      if (a_ack !== 1'b0)  begin bad++; $display("FAIL reset_a_ack: got %b required 0", a_ack); end
      if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_a_busy: got %b required 0", a_busy); end
      if (a_err !== 1'b0)  begin bad++; $display("FAIL reset_a_err: got %b required 0", a_err); end
      if ({a_dout[0], a_dout[1], a_dout[2], a_dout[3]} !== 32'h0) begin
         bad++;
         $display("FAIL reset_a_data: got %h required 0", {a_dout[0], a_dout[1], a_dout[2], a_dout[3]});
      end
      if (b_ack !== 1'b0)  begin bad++; $display("FAIL reset_b_ack: got %b required 0", b_ack); end
      if (b_busy !== 1'b0) begin bad++; $display("FAIL reset_b_busy: got %b required 0", b_busy); end
      if (b_err !== 1'b0)  begin bad++; $display("FAIL reset_b_err: got %b required 0", b_err); end
      if ({b_dout[0], b_dout[1], b_dout[2], b_dout[3]} !== 32'h0) begin
         bad++;
         $display("FAIL reset_b_data: got %h required 0", {b_dout[0], b_dout[1], b_dout[2], b_dout[3]});
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read();
      do_req(32'h0000_0010, 1'b1, 4'hF, 32'hAABB_CCDD, 1'b0);
      do_req(32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_partial_write();
      do_req(32'h0000_0012, 1'b1, 4'b0101, 32'h1122_3344, 1'b0);
      do_req(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b0);
      do_req(32'h0000_0010, 1'b1, 4'b0000, 32'h9999_9999, 1'b0);
   endtask

   task automatic test_out_of_range();
      do_req(32'h0000_0000, 1'b1, 4'hF, 32'h0102_0304, 1'b0);
      do_req(32'h0001_0000, 1'b1, 4'hF, 32'hEEEE_EEEE, 1'b0);
      do_req(32'h0000_0000, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_reset_mid_wait();
      do_req(32'h0000_0020, 1'b1, 4'hF, 32'h0001_0203, 1'b0);
      drive_a(32'h0000_0020, 1'b1, 4'hF, 32'hFFFF_FFFF);
      a_req = 1'b1;
      @(posedge clk);
      #1;
      a_req = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      total += 4;
      if (a_ack !== 1'b0)  begin bad++; $display("FAIL midreset_ack: got %b required 0", a_ack); end
      if (a_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b required 0", a_busy); end
      if (a_err !== 1'b0)  begin bad++; $display("FAIL midreset_err: got %b required 0", a_err); end
      if ({a_dout[0], a_dout[1], a_dout[2], a_dout[3]} !== 32'h0) begin
         bad++;
         $display("FAIL midreset_data: got %h required 0", {a_dout[0], a_dout[1], a_dout[2], a_dout[3]});
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      do_req(32'h0000_0020, 1'b0, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic test_input_churn();
      do_req(32'h0000_0034, 1'b1, 4'hF, 32'h0000_0000, 1'b0);
      do_req(32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b1);
      do_req(32'h0000_0034, 1'b1, 4'b1010, 32'h5AA5_3CC3, 1'b1);
      do_req(32'h0000_0034, 1'b0, 4'h0, 32'h0, 1'b1);
   endtask

   // Four requests with mem_req held high: write 0x40, write 0x44, read 0x40, read 0x44.
   task automatic test_back_to_back();
      logic [31:0] addr_t [4];
      logic [31:0] data_t [4];
      logic        we_t   [4];
      exp_t        e;
      addr_t = '{32'h40, 32'h44, 32'h40, 32'h44};
      data_t = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'h0};
      we_t   = '{1'b1, 1'b1, 1'b0, 1'b0};
      b_req  = 1'b1;
      for (int j = 0; j < 4; j++) begin
         b_addr = addr_t[j];
         b_we   = we_t[j];
         b_be   = 4'hF;
         for (int i = 0; i < 4; i++) b_din[i] = data_t[j][31-8*i -: 8];
         @(posedge clk);
         #1;
         e.cyc  = cyc;
         e.err  = 1'b0;
         e.data = (addr_t[j] == 32'h40) ? 32'hDEAD_BEEF : 32'h1234_5678;
         q_b.push_back(e);
         if (j == 3) b_req = 1'b0;
         for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            #1;
            total += 2;
            if (b_busy !== (t != 2)) begin
               bad++;
               $display("FAIL b2b_busy: req %0d cycle %0d got %b required %b", j, t, b_busy, (t != 2));
            end
            if (b_ack !== (t == 1)) begin
               bad++;
               $display("FAIL b2b_ack: req %0d cycle %0d got %b required %b", j, t, b_ack, (t == 1));
            end
         end
      end
   endtask

   initial begin
      cyc        = 0;
      total      = 0;
      bad        = 0;
      acks_a     = 0;
      a_prev_ack = 1'b0;
      b_prev_ack = 1'b0;
      reset      = 1'b1;
      a_req      = 1'b0;
      b_req      = 1'b0;
      drive_a(32'h0, 1'b0, 4'h0, 32'h0);
      b_addr = 32'h0;
      b_we   = 1'b0;
      b_be   = 4'h0;
      for (int i = 0; i < 4; i++) b_din[i] = 8'h00;

      test_reset();
      test_write_read();
      test_partial_write();
      test_out_of_range();
      test_reset_mid_wait();
      test_input_churn();
      test_back_to_back();

      repeat (3) @(posedge clk);
      #1;
      total++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d/%0d responses outstanding, required 0/0", q_a.size(), q_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
